// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
//
// Purpose: FSM state encoding and default address/data widths used by dmem_arbiter.
// Ports:   none (package).

package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port BRAM arbiter, CPU priority over DMA bursts
//
// Purpose: shares one BRAM port between a never-stalled CPU and a DMA burst
//          engine. The CPU always wins; a displaced DMA beat is reissued on the
//          next free cycle with the same index.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_ren/cpu_wren/cpu_addr/
//   cpu_wdata, cpu_rdata           CPU load/store port (rdata valid cycle after ren)
//   dma_req/dma_we/dma_addr/
//   dma_len/dma_wdata              burst request (sampled in IDLE), write beat data
//   dma_gnt/dma_beat/dma_rvalid/
//   dma_done/dma_rdata             burst handshakes and read return
//   bram_en/bram_we/bram_addr/
//   bram_wdata, bram_rdata         BRAM port, 1-cycle read latency
//   stat_conflicts, stat_beats     only with DMEM_ARB_STATS_EN: saturating counters
// Configuration: define DMEM_ARB_STATS_EN to add the statistics counters.

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ren,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_beat,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_beats,
`endif
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  arb_state_t        state, state_nxt;
  logic [7:0]        idx, idx_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_len;
  logic              rd_pend;
  logic              cpu_acc;

  assign cpu_acc = cpu_ren | cpu_wren;

  // The BRAM returns data one cycle after the read; both requesters see it,
  // and rd_pend marks the cycles where it belongs to a DMA read beat.
  assign cpu_rdata  = bram_rdata;
  assign dma_rdata  = bram_rdata;
  assign dma_rvalid = rd_pend & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 8'd0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_len  <= 8'd0;
      rd_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      rd_pend <= dma_beat & ~lat_we;
      if (state == IDLE && dma_req) begin
        lat_we   <= dma_we;
        lat_addr <= dma_addr;
        lat_len  <= dma_len;
      end
    end
  end

  // Outputs are held inactive while rst is high so an abandoned burst
  // cannot leak a beat, a done or a read return during the reset cycle.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    dma_gnt    = 1'b0;
    dma_beat   = 1'b0;
    dma_done   = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (!rst) begin
      if (cpu_acc) begin
        bram_en    = 1'b1;
        bram_we    = cpu_wren;
        bram_addr  = cpu_addr;
        bram_wdata = cpu_wdata;
      end
      case (state)
        IDLE: begin
          if (dma_req) begin
            dma_gnt   = 1'b1;
            idx_nxt   = 8'd0;
            state_nxt = BURST;
          end
        end
        BURST: begin
          if (!cpu_acc) begin
            dma_beat   = 1'b1;
            bram_en    = 1'b1;
            bram_we    = lat_we;
            bram_addr  = lat_addr + ADDR_W'(idx);
            bram_wdata = dma_wdata;
            idx_nxt    = idx + 8'd1;
            if (idx == lat_len) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          dma_done  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts <= 16'd0;
      stat_beats     <= 16'd0;
    end else begin
      if (state == BURST && cpu_acc && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (dma_beat && stat_beats != 16'hFFFF)
        stat_beats <= stat_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a BRAM model

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wren;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_len;
  logic [15:0] dma_wdata;
  logic        dma_gnt, dma_beat, dma_rvalid, dma_done;
  logic [15:0] dma_rdata;
  logic        bram_en, bram_we;
  logic [15:0] bram_addr, bram_wdata;
  logic [15:0] bram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_beats;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
    .dma_rvalid(dma_rvalid), .dma_done(dma_done), .dma_rdata(dma_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_beats(stat_beats),
`endif
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM model: 1-cycle read latency, preloaded with a pattern.
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    bram_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } beat_t;
  beat_t       beat_q[$];
  logic [15:0] rd_q[$];

  always @(negedge clk) begin
    if (dma_beat) begin
      if (beat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got addr %0h expected no beat", bram_addr);
      end else begin
        beat_t b;
        b = beat_q.pop_front();
        check("beat_addr", bram_addr, b.addr);
        check("beat_we", bram_we, b.we);
        if (b.we) check("beat_wdata", bram_wdata, b.wdata);
      end
    end
    if (dma_rvalid) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: got data %0h expected no rvalid", dma_rdata);
      end else begin
        logic [15:0] e;
        e = rd_q.pop_front();
        check("dma_rdata", dma_rdata, e);
      end
    end
  end

  task automatic idle_inputs();
    rst = 1'b0; cpu_ren = 1'b0; cpu_wren = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_len = 8'h0; dma_wdata = 16'h0;
  endtask

  task automatic exp_burst(input logic we, input logic [15:0] base, input int nbeat, input int nrd);
    for (int i = 0; i < nbeat; i++) begin
      beat_t b;
      b.addr  = base + 16'(i);
      b.we    = we;
      b.wdata = 16'hD000 ^ b.addr;
      beat_q.push_back(b);
      if (!we && i < nrd) rd_q.push_back(pat(b.addr));
    end
  endtask

  // Drives one burst; cycle 0 raises dma_req. Optional single CPU access at
  // cpu_cyc and reset pulse at rst_cyc. Request/address/length are scrambled
  // after the grant to confirm they are ignored.
  task automatic run_burst(input logic we, input logic [15:0] base, input logic [7:0] len,
                           input int cpu_cyc, input logic cpu_w, input logic [15:0] cpu_a,
                           input logic [15:0] cpu_d, input int rst_cyc, output int done_cyc);
    int nb;
    nb = 0;
    done_cyc = -1;
    for (int c = 0; c < int'(len) + 20; c++) begin
      @(posedge clk); #1;
      dma_req   = (c == 0) || (rst_cyc < 0 && c >= 2);
      dma_we    = (c == 0) ? we : ~we;
      dma_addr  = (c == 0) ? base : 16'h7777;
      dma_len   = (c == 0) ? len : 8'hFF;
      dma_wdata = 16'hD000 ^ (base + 16'(nb));
      cpu_ren   = (c == cpu_cyc) && !cpu_w;
      cpu_wren  = (c == cpu_cyc) && cpu_w;
      cpu_addr  = cpu_a;
      cpu_wdata = cpu_d;
      rst       = (c == rst_cyc);
      @(negedge clk);
      if (c == 0) check("dma_gnt", dma_gnt, 1);
      if (c == cpu_cyc) begin
        check("cpu_prio_en", bram_en, 1);
        check("cpu_prio_addr", bram_addr, cpu_a);
        check("cpu_prio_nobeat", dma_beat, 0);
      end
      if (rst_cyc >= 0 && c > rst_cyc) check("post_rst_en", bram_en, 0);
      if (dma_beat) nb++;
      if (dma_done) begin
        done_cyc = c;
        break;
      end
      if (rst_cyc >= 0 && c >= rst_cyc + 5) break;
    end
    idle_inputs();
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    cpu_ren = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    cpu_ren = 1'b0;
    @(negedge clk);
    check("cpu_readback", cpu_rdata, exp);
  endtask

  typedef struct {
    logic        ren;
    logic        wren;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_en;
    logic        exp_we;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[6];
  int   dc;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 16'h0030, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hABCD};
    vecs[5] = '{1'b0, 1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

    idle_inputs();
    rst = 1'b1;
    cpu_wren = 1'b1; dma_req = 1'b1;
    @(negedge clk);
    check("rst_gnt", dma_gnt, 0);
    check("rst_beat", dma_beat, 0);
    check("rst_rvalid", dma_rvalid, 0);
    check("rst_done", dma_done, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    @(posedge clk); #1;
    idle_inputs();

    // CPU-only vectors in IDLE
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cpu_ren = vecs[i].ren; cpu_wren = vecs[i].wren;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      @(negedge clk);
      check("vec_en", bram_en, vecs[i].exp_en);
      check("vec_we", bram_we, vecs[i].exp_we);
      if (vecs[i].exp_en) check("vec_addr", bram_addr, vecs[i].addr);
      if (vecs[i].exp_we) check("vec_wdata", bram_wdata, vecs[i].wdata);
      if (i > 0 && vecs[i-1].chk_rd) check("vec_cpu_rdata", cpu_rdata, vecs[i-1].exp_rd);
    end
    idle_inputs();

    // Read burst, len 3
    exp_burst(1'b0, 16'h0100, 4, 4);
    run_burst(1'b0, 16'h0100, 8'd3, -1, 1'b0, 16'h0, 16'h0, -1, dc);
    check("rd4_done_cycle", dc, 5);

    // Write burst len 1, CPU read on first BURST cycle
    exp_burst(1'b1, 16'h0200, 2, 0);
    run_burst(1'b1, 16'h0200, 8'd1, 1, 1'b0, 16'h0040, 16'h0, -1, dc);
    check("wr2_done_cycle", dc, 4);
`ifdef DMEM_ARB_STATS_EN
    check("stat_conflicts", stat_conflicts, 1);
`endif
    cpu_rd(16'h0200, 16'hD200);
    cpu_rd(16'h0201, 16'hD201);

    // Address wrap
    exp_burst(1'b0, 16'hFFFE, 4, 4);
    run_burst(1'b0, 16'hFFFE, 8'd3, -1, 1'b0, 16'h0, 16'h0, -1, dc);
    check("wrap_done_cycle", dc, 5);

    // Single-word write
    exp_burst(1'b1, 16'h0300, 1, 0);
    run_burst(1'b1, 16'h0300, 8'd0, -1, 1'b0, 16'h0, 16'h0, -1, dc);
    check("len0_done_cycle", dc, 2);
    cpu_rd(16'h0300, 16'hD300);

    // Reset after two of four read beats
    exp_burst(1'b0, 16'h0400, 2, 1);
    run_burst(1'b0, 16'h0400, 8'd3, -1, 1'b0, 16'h0, 16'h0, 3, dc);
    check("rst_no_done", dc, 32'hFFFF_FFFF);

    // CPU write collides with DMA read beat; reissued beat sees new data
    begin
      beat_t b;
      b.addr = 16'h0010; b.we = 1'b0; b.wdata = 16'hD010;
      beat_q.push_back(b);
      rd_q.push_back(16'hBEEF);
    end
    run_burst(1'b0, 16'h0010, 8'd0, 1, 1'b1, 16'h0010, 16'hBEEF, -1, dc);
    check("beef_done_cycle", dc, 3);

    // Maximum length burst
    exp_burst(1'b0, 16'h1000, 256, 256);
    run_burst(1'b0, 16'h1000, 8'd255, -1, 1'b0, 16'h0, 16'h0, -1, dc);
    check("len255_done_cycle", dc, 257);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("beat_q_empty", beat_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, BRAM address width.
REQ-002 Parameter: DATA_W, default 16, BRAM data width.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-005 Port: cpu_ren / cpu_wren  input  1 each  CPU read / write strobe, single cycle, never stalled.
REQ-006 Port: cpu_addr, cpu_wdata  input  ADDR_W / DATA_W  CPU address and store data.
REQ-007 Port: cpu_rdata  output  DATA_W  CPU load data, valid cycle after cpu_ren.
REQ-008 Port: dma_req  input  1  accelerator burst request, level, sampled only in IDLE.
REQ-009 Port: dma_we  input  1  burst direction (1 write, 0 read), sampled with dma_req.
REQ-010 Port: dma_addr, dma_len  input  ADDR_W / 8  burst base address; word count minus one.
REQ-011 Port: dma_wdata  input  DATA_W  write-burst data for the current beat.
REQ-012 Port: dma_gnt, dma_beat, dma_rvalid, dma_done  output  1 each  burst accepted; beat issued; read data valid; burst complete.
REQ-013 Port: dma_rdata  output  DATA_W  DMA read data.
REQ-014 Port: bram_en, bram_we  output  1 each; bram_addr, bram_wdata  output  ADDR_W / DATA_W; bram_rdata  input  DATA_W  BRAM port, 1-cycle read latency.

Function
REQ-015 FSM states IDLE, BURST, DRAIN; reset state IDLE.
REQ-016 IDLE: dma_req=1 -> latch dma_we, dma_addr, dma_len, clear beat index; dma_gnt=1 for exactly that cycle; next state BURST.
REQ-017 CPU has absolute priority: any cycle with cpu_ren|cpu_wren drives BRAM from CPU port (bram_we=cpu_wren); no DMA beat that cycle.
REQ-018 BURST, no CPU access: issue beat at bram_addr = base + index (mod 2^ADDR_W, wraps 0xFFFF->0x0000), bram_we=latched dma_we, bram_wdata=dma_wdata; dma_beat=1; index increments.
REQ-019 Beat with index==len -> next state DRAIN; burst length = dma_len+1 (0 -> 1 word, 255 -> 256 words).
REQ-020 DRAIN: one cycle; dma_done=1 for one cycle; next state IDLE; dma_req in DRAIN ignored.
REQ-021 dma_rvalid=1 and dma_rdata=bram_rdata in cycle after each DMA read beat; never for write beats.
REQ-022 cpu_rdata = bram_rdata unconditionally (combinational passthrough).
REQ-023 CPU write and DMA read of same address: CPU wins that cycle; DMA beat reissued next free cycle, reads updated value.
REQ-024 dma_req changes or dma_addr/dma_len changes during BURST/DRAIN: no effect.
REQ-025 No CPU access, no DMA beat: bram_en=0, bram_we=0.
REQ-026 cpu_ren and cpu_wren both high: treated as write (bram_we=1).

Reset
REQ-027 rst=1: state IDLE, index 0, dma_gnt/dma_beat/dma_rvalid/dma_done/bram_en/bram_we=0, latched registers 0.
REQ-028 rst mid-burst: burst abandoned, no dma_done, no further dma_rvalid.

Configuration
REQ-029 Macro DMEM_ARB_STATS_EN defined: add outputs stat_conflicts[15:0] (cycles in BURST with CPU access) and stat_beats[15:0] (DMA beats issued), saturating at 0xFFFF, cleared by rst.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package dmem_arb_pkg holds FSM state enum (IDLE, BURST, DRAIN) and default width constants.
REQ-032 Single module; no sub-modules; stats counters inline under the macro.

Verification
REQ-033 dma_req, we=0, addr=0x0100, len=3, no CPU traffic -> gnt cycle 0; beats at 0x0100..0x0103 cycles 1-4; rvalid cycles 2-5; dma_done cycle 5.
REQ-034 Write burst addr=0x0200, len=1, cpu_ren on first BURST cycle -> CPU read at cpu_addr, beats to 0x0200/0x0201 delayed one cycle; stat_conflicts=1 with macro.
REQ-035 addr=0xFFFE, len=3 -> beat addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 len=0 write -> exactly one beat, one dma_done, zero dma_rvalid.
REQ-037 rst asserted after 2 of 4 read beats -> IDLE next cycle, no dma_done, no further bram_en from DMA.
REQ-038 CPU writes 0xBEEF to 0x0010 in same cycle as DMA read beat to 0x0010 -> dma_rdata=0xBEEF.
